// File: rtl/cp0_exc_if.sv
// cp0_exc_if - M-stage <-> CP0 bundle.
//   master (pipeline): drives mfc0/mtc0 controls, victim PC/BD, exception code,
//                      eret and device interrupt lines; receives CP0Out/EPCOut/Req.
//   slave  (CP0):      the mirror image.
interface cp0_exc_if;
  logic [4:0]  A1;         // mfc0 read register number
  logic [4:0]  A2;         // mtc0 write register number
  logic [31:0] DIn;        // mtc0 write data
  logic        EN;         // mtc0 write enable
  logic [31:0] PC_M;       // victim PC
  logic        BD_M;       // victim sits in a branch delay slot
  logic [4:0]  ExcCode_M;  // exception code from earlier stages, 0 = none
  logic        EXLClr;     // eret in M
  logic [5:0]  HWInt;      // level-sensitive device interrupts
  logic [31:0] CP0Out;     // mfc0 read data
  logic [31:0] EPCOut;     // eret target
  logic        Req;        // flush/redirect request

  modport master (
    output A1, A2, DIn, EN, PC_M, BD_M, ExcCode_M, EXLClr, HWInt,
    input  CP0Out, EPCOut, Req
  );
  modport slave (
    input  A1, A2, DIn, EN, PC_M, BD_M, ExcCode_M, EXLClr, HWInt,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit - Coprocessor 0 for the P7 pipeline (M stage).
//   Holds SR(12), Cause(13), EPC(14), PRId(15); evaluates hardware interrupts and
//   M-stage exceptions and raises Req, the zero-latency flush/redirect request.
// Ports:
//   clk   - clock, posedge
//   reset - synchronous, active-high
//   bus   - cp0_exc_if.slave (mfc0/mtc0, victim info, eret, HWInt, CP0Out/EPCOut/Req)
module cp0_exc_unit #(
  parameter logic [31:0] PRID    = 32'h0000_5037,
  parameter int          HWINT_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  cp0_exc_if.slave   bus
);

  // SR fields
  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  // Cause fields
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [4:0]         exccode_q, exccode_d;
  // EPC, low two bits held at zero
  logic [31:0]        epc_q, epc_d;

  logic int_req, exc_req, req;

  assign int_req = ie_q & ~exl_q & (|(bus.HWInt & im_q));
  assign exc_req = ~exl_q & (bus.ExcCode_M != 5'd0);
  // Reset must kill Req in the same cycle so a held reset never flushes.
  assign req     = ~reset & (int_req | exc_req);
  assign bus.Req = req;

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    // IP samples the lines on every edge, Req edges included, so a pending
    // interrupt stays visible while nested interrupts are blocked by EXL.
    ip_d      = bus.HWInt;

    if (req) begin
      exl_d     = 1'b1;
      exccode_d = int_req ? 5'd0 : bus.ExcCode_M;
      bd_d      = bus.BD_M;
      epc_d     = (bus.BD_M ? bus.PC_M - 32'd4 : bus.PC_M) & ~32'd3;
    end else begin
      if (bus.EN) begin
        case (bus.A2)
          5'd12: begin
            im_d  = bus.DIn[15:10];
            exl_d = bus.DIn[1];
            ie_d  = bus.DIn[0];
          end
          5'd14:   epc_d = bus.DIn & ~32'd3;
          default: ;
        endcase
      end
      // eret clears EXL after any same-cycle SR write.
      if (bus.EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  // Registered state only: an mtc0 shows up on CP0Out the cycle after its edge.
  always_comb begin
    bus.CP0Out = 32'd0;
    case (bus.A1)
      5'd12: bus.CP0Out = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13: bus.CP0Out = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
      5'd14: bus.CP0Out = epc_q;
      5'd15: bus.CP0Out = PRID;
      default: bus.CP0Out = 32'd0;
    endcase
  end

  assign bus.EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] PRID = 32'h0000_5037;

  cp0_exc_if bus ();
  cp0_exc_unit #(.PRID(PRID), .HWINT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // inputs change 1 time unit after posedge; checks run mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; bus.HWInt = 6'h3F;
    tick(); tick();
    #2;
    n_checks++; if (bus.Req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", bus.Req); end
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_cause got=%h exp=0", v); end
    n_checks++; if (bus.EPCOut !== 32'd0) begin n_fail++; $display("FAIL reset_epc got=%h exp=0", bus.EPCOut); end
    bus.A1 = 5'd15; #1; v = bus.CP0Out;
    n_checks++; if (v !== PRID) begin n_fail++; $display("FAIL prid got=%h exp=%h", v, PRID); end
    reset = 1'b0;
    tick();
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_FC00) begin n_fail++; $display("FAIL cause_ip got=%h exp=0000fc00", v); end
    n_checks++; if (bus.Req !== 1'b0) begin n_fail++; $display("FAIL ie0_req got=%b exp=0", bus.Req); end
  endtask

  task automatic test_mtc0_int();
    logic [31:0] v;
    bus.HWInt = 6'h00; bus.EN = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    tick();
    bus.EN = 1'b0; bus.A1 = 5'd12; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0401) begin n_fail++; $display("FAIL sr_write got=%h exp=00000401", v); end
    bus.HWInt = 6'h01; bus.PC_M = 32'h0000_1000; bus.BD_M = 1'b0; #1;
    n_checks++; if (bus.Req !== 1'b1) begin n_fail++; $display("FAIL int_req got=%b exp=1", bus.Req); end
    tick();
    bus.A1 = 5'd12; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0403) begin n_fail++; $display("FAIL int_sr got=%h exp=00000403", v); end
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0400) begin n_fail++; $display("FAIL int_cause got=%h exp=00000400", v); end
    n_checks++; if (bus.EPCOut !== 32'h0000_1000) begin n_fail++; $display("FAIL int_epc got=%h exp=00001000", bus.EPCOut); end
    n_checks++; if (bus.Req !== 1'b0) begin n_fail++; $display("FAIL int_req_drop got=%b exp=0", bus.Req); end
  endtask

  task automatic test_exc_bd();
    logic [31:0] v;
    bus.HWInt = 6'h00; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0; bus.A1 = 5'd12; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0401) begin n_fail++; $display("FAIL eret_sr got=%h exp=00000401", v); end
    n_checks++; if (bus.EPCOut !== 32'h0000_1000) begin n_fail++; $display("FAIL eret_epc_kept got=%h exp=00001000", bus.EPCOut); end
    bus.ExcCode_M = 5'd4; bus.BD_M = 1'b1; bus.PC_M = 32'h0000_3008; #1;
    n_checks++; if (bus.Req !== 1'b1) begin n_fail++; $display("FAIL exc_req got=%b exp=1", bus.Req); end
    tick();
    bus.ExcCode_M = 5'd0; bus.BD_M = 1'b0;
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h8000_0010) begin n_fail++; $display("FAIL exc_cause got=%h exp=80000010", v); end
    n_checks++; if (bus.EPCOut !== 32'h0000_3004) begin n_fail++; $display("FAIL exc_epc got=%h exp=00003004", bus.EPCOut); end
  endtask

  task automatic test_int_beats_exc();
    logic [31:0] v;
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    bus.HWInt = 6'h01; bus.ExcCode_M = 5'd12; bus.PC_M = 32'h0000_2000; #1;
    n_checks++; if (bus.Req !== 1'b1) begin n_fail++; $display("FAIL both_req got=%b exp=1", bus.Req); end
    tick();
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0400) begin n_fail++; $display("FAIL both_cause got=%h exp=00000400", v); end
    n_checks++; if (bus.EPCOut !== 32'h0000_2000) begin n_fail++; $display("FAIL both_epc got=%h exp=00002000", bus.EPCOut); end
    // nested: EXL=1 blocks both interrupt and exception
    bus.ExcCode_M = 5'd5; #1;
    n_checks++; if (bus.Req !== 1'b0) begin n_fail++; $display("FAIL nested_req got=%b exp=0", bus.Req); end
    bus.ExcCode_M = 5'd0; bus.EXLClr = 1'b1; #1;
    n_checks++; if (bus.Req !== 1'b0) begin n_fail++; $display("FAIL eret_cycle_req got=%b exp=0", bus.Req); end
    tick();
    bus.EXLClr = 1'b0; #1;
    n_checks++; if (bus.Req !== 1'b1) begin n_fail++; $display("FAIL reassert_req got=%b exp=1", bus.Req); end
  endtask

  task automatic test_req_ignores_mtc0();
    bus.EN = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_FFFF; bus.PC_M = 32'h0000_4000;
    tick();
    bus.EN = 1'b0; #1;
    n_checks++; if (bus.EPCOut !== 32'h0000_4000) begin n_fail++; $display("FAIL req_mtc0_epc got=%h exp=00004000", bus.EPCOut); end
  endtask

  task automatic test_mtc0_regs();
    logic [31:0] v;
    bus.HWInt = 6'h00;
    bus.EN = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0; bus.A1 = 5'd12; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0401) begin n_fail++; $display("FAIL eret_mtc0_sr got=%h exp=00000401", v); end
    bus.A2 = 5'd14; bus.DIn = 32'h0000_1237;
    tick();
    #1;
    n_checks++; if (bus.EPCOut !== 32'h0000_1234) begin n_fail++; $display("FAIL mtc0_epc got=%h exp=00001234", bus.EPCOut); end
    bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    tick();
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0000) begin n_fail++; $display("FAIL cause_ro got=%h exp=00000000", v); end
    bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF;
    tick();
    bus.EN = 1'b0; bus.A1 = 5'd12; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_FC03) begin n_fail++; $display("FAIL sr_mask got=%h exp=0000fc03", v); end
    bus.A1 = 5'd16; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'h0000_0000) begin n_fail++; $display("FAIL unmapped got=%h exp=00000000", v); end
  endtask

  task automatic test_reset_req();
    logic [31:0] v;
    bus.EN = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01; bus.EXLClr = 1'b1;
    tick();
    bus.EN = 1'b0; bus.EXLClr = 1'b0; bus.HWInt = 6'h3F; #1;
    n_checks++; if (bus.Req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req got=%b exp=1", bus.Req); end
    reset = 1'b1; #1;
    n_checks++; if (bus.Req !== 1'b0) begin n_fail++; $display("FAIL reset_kills_req got=%b exp=0", bus.Req); end
    tick();
    bus.A1 = 5'd12; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_sr got=%h exp=0", v); end
    bus.A1 = 5'd13; #1; v = bus.CP0Out;
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_cause got=%h exp=0", v); end
    n_checks++; if (bus.EPCOut !== 32'd0) begin n_fail++; $display("FAIL rst_epc got=%h exp=0", bus.EPCOut); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.EN = 1'b0;
    bus.PC_M = 32'd0; bus.BD_M = 1'b0; bus.ExcCode_M = 5'd0;
    bus.EXLClr = 1'b0; bus.HWInt = 6'd0;
    #1;
    test_reset();
    test_mtc0_int();
    test_exc_bd();
    test_int_beats_exc();
    test_req_ignores_mtc0();
    test_mtc0_regs();
    test_reset_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
